// File: rtl/fastmul.sv
// fastmul: sequential shift-add multiply-accumulate, xout = qin * yin + rin.
// Latency: 8 clocks from the accept edge to xout/done; one result per 9 cycles back-to-back.
// Backpressure: none; enbl is level-sampled in IDLE/DONE and ignored while busy.
module fastmul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enbl,
  input  logic [7:0]  qin,
  input  logic [7:0]  yin,
  input  logic [7:0]  rin,
  output logic [15:0] xout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'd7;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] xout_q, xout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Partial product for the current iteration and the running sum it produces.
  // The maximum result (255*255+255) fits in 16 bits, so no carry-out is kept.
  logic [15:0] addend;
  logic [15:0] sum;
  logic        can_accept;
  logic        operand_err;

  // Datapath helpers shared by the accept and iterate paths.
  always_comb begin
    addend      = mplier_q[0] ? mcand_q : 16'd0;
    sum         = acc_q + addend;
    can_accept  = (state_q == S_IDLE) || (state_q == S_DONE);
    // Flags operands that cannot have come from a valid division.
    operand_err = (yin == 8'd0) || (rin >= yin);
  end

  // Next-state and registered-output logic for the control FSM and datapath.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    xout_d   = xout_q;
    busy_d   = busy_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (can_accept && enbl) begin
          // Operands are latched here; later input changes have no effect.
          acc_d    = {8'd0, rin};
          mcand_d  = {8'd0, yin};
          mplier_d = qin;
          cnt_d    = 3'd0;
          err_d    = operand_err;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_CALC: begin
        // Always exactly 8 iterations, even if the multiplier runs out early,
        // so the latency is fixed regardless of operand values.
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          xout_d  = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      cnt_q    <= 3'd0;
      xout_q   <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      xout_q   <= xout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign xout = xout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_fastmul.sv
// Testbench for fastmul: directed and random operands, scoreboard checked on done.
// Expected results come from plain integer arithmetic on the applied operands.
// A monitor pops the scoreboard on every done pulse and checks value, flag, latency and busy.
module tb_fastmul;

  logic        clk;
  logic        rst_n;
  logic        enbl;
  logic [7:0]  qin, yin, rin;
  logic [15:0] xout;
  logic        busy, done, err;

  fastmul dut (
    .clk  (clk),
    .rst_n(rst_n),
    .enbl (enbl),
    .qin  (qin),
    .yin  (yin),
    .rin  (rin),
    .xout (xout),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  typedef struct {
    int unsigned x;
    bit          e;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          busy_run = 0;
  int unsigned last_x   = 0;
  bit          last_e   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic exp_t model(input int q, input int y, input int r, input int c);
    exp_t t;
    t.x   = q * y + r;
    t.e   = (y == 0) || (r >= y);
    t.cyc = c;
    return t;
  endfunction

  // Monitor: compares every done pulse against the oldest outstanding expectation.
  initial begin
    exp_t t;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          t = sb.pop_front();
          chk("xout", xout, t.x);
          chk("err_at_done", err, t.e);
          chk("latency", cyc - t.cyc, 8);
          chk("busy_cycles", busy_run, 8);
          chk("busy_with_done", busy, 0);
        end
      end
      busy_run = busy ? busy_run + 1 : 0;
    end
  end

  // Waits for all outstanding results, bounded so a stuck DUT cannot hang the run.
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Pulses enbl for one cycle with the given operands; optionally scrambles them during CALC.
  task automatic run_op(input int q, input int y, input int r, input bit scramble);
    exp_t t;
    @(negedge clk);
    qin = q[7:0]; yin = y[7:0]; rin = r[7:0]; enbl = 1'b1;
    @(posedge clk);
    #1;
    t = model(q, y, r, cyc);
    sb.push_back(t);
    last_x = t.x; last_e = t.e;
    chk("err_at_accept", err, t.e);
    enbl = 1'b0;
    if (scramble) begin
      qin = 8'($urandom); yin = 8'($urandom); rin = 8'($urandom);
    end
    wait_drain();
  endtask

  initial begin
    exp_t t;
    int q, y, r;
    rst_n = 1'b0; enbl = 1'b0; qin = '0; yin = '0; rin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_xout", xout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(32, 2, 0, 1'b1);
    run_op(2, 2, 1, 1'b0);
    run_op(5, 4, 1, 1'b0);
    run_op(27, 3, 0, 1'b0);
    run_op(42, 3, 2, 1'b0);
    run_op(255, 255, 254, 1'b1);
    run_op(0, 7, 3, 1'b0);
    run_op(9, 0, 0, 1'b0);
    run_op(4, 5, 5, 1'b0);

    // Idle hold: result and flag stay put with enbl low.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_xout", xout, last_x);
    chk("hold_err", err, last_e);

    // Back-to-back with enbl held high; operands change during CALC and are
    // only picked up at the next accept, 9 cycles later.
    @(negedge clk);
    qin = 8'd13; yin = 8'd11; rin = 8'd7; enbl = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(13, 11, 7, cyc));
    for (int k = 0; k < 3; k++) begin
      q = $urandom_range(255); y = $urandom_range(255); r = $urandom_range(255);
      qin = q[7:0]; yin = y[7:0]; rin = r[7:0];
      repeat (9) @(posedge clk);
      #1;
      t = model(q, y, r, cyc);
      sb.push_back(t);
      chk("b2b_err_at_accept", err, t.e);
      last_x = t.x; last_e = t.e;
    end
    enbl = 1'b0;
    wait_drain();

    // Reset mid-CALC: aborts with no done pulse and clears outputs.
    @(negedge clk);
    qin = 8'd9; yin = 8'd0; rin = 8'd0; enbl = 1'b1;
    @(posedge clk);
    #1;
    enbl = 1'b0;
    chk("abort_err_set", err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_xout", xout, 0);
    chk("abort_err", err, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    run_op(10, 10, 9, 1'b0);

    // Random operations, mostly divider-consistent, some not.
    for (int i = 0; i < 30; i++) begin
      q = $urandom_range(255);
      y = $urandom_range(255);
      if ($urandom_range(3) == 0 || y == 0) r = $urandom_range(255);
      else r = $urandom_range(y - 1);
      run_op(q, y, r, ($urandom_range(1) == 1));
      repeat ($urandom_range(3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fastmul.md
# fastmul

Sequential shift-add multiply-accumulate unit that reconstructs a dividend from a quotient, divisor and remainder: xout = qin * yin + rin. It is the inverse-direction companion of the `fastdiv` divider and shares its 8-bit operand / 16-bit result format and `enbl` start convention. It runs standalone as a multiplier with `rin = 0`, or in the divider bench's self-check path to confirm that a divider result reproduces the original dividend.

## Interface
- No parameters; operand width fixed at 8 bits, result width at 16 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `enbl` input 1: start request; level-sampled; accepted only in IDLE or DONE.
- `qin` input 8: unsigned multiplier (quotient).
- `yin` input 8: unsigned multiplicand (divisor).
- `rin` input 8: unsigned addend (remainder).
- `xout` output 16: unsigned result; registered; holds the last result until the next result is written.
- `busy` output 1: high while in CALC.
- `done` output 1: one-cycle pulse when `xout` is updated.
- `err` output 1: consistency flag for the accepted operands; set when `yin == 0` or `rin >= yin`; held until the next accept.

## Operation
- States:
  - IDLE (reset state).
  - CALC: 8 iterations.
  - DONE: 1 cycle.
- Accept (IDLE or DONE, `enbl = 1`):
  - Load `acc <= {8'b0, rin}`, `mcand <= {8'b0, yin}`, `mplier <= qin`, `cnt <= 0`.
  - Compute `err` from the accepted `yin`/`rin` and register it.
  - Go to CALC.
- CALC, each cycle:
  - If `mplier[0]`, then `acc <= acc + mcand`.
  - `mcand <= mcand << 1`; `mplier <= mplier >> 1`; `cnt <= cnt + 1`.
  - Always exactly 8 iterations. No early termination, even when `qin == 0`.
- Exit CALC: on the 8th iteration (`cnt == 7`), write the final accumulator sum to `xout`, set `done <= 1`, go to DONE.
- DONE:
  - `done` drops on the next edge.
  - If `enbl = 1`, accept a new operation directly (to CALC). Otherwise go to IDLE.
- Width rules:
  - Maximum result is 255*255 + 255 = 65280 < 2^16, so no overflow is possible and the accumulator needs no carry-out.
  - `mcand` is 16 bits; bits shifted beyond bit 15 never occur within 8 iterations.
- `err` is informational only. The result is always computed as qin*yin + rin regardless of `err`.
- `enbl` is ignored while in CALC. Operands are latched at accept, so `qin`/`yin`/`rin` may change freely afterwards.

## Timing
- Reset values: `xout = 16'h0000`, `busy = 0`, `done = 0`, `err = 0`, state IDLE; internal registers cleared.
- Reset has priority over all other activity. Asserting `rst_n = 0` mid-CALC aborts the operation at that edge: no `done` pulse, `xout` returns to 0.
- Let the accept edge be E0:
  - `busy` is high after E0 through E8.
  - `xout`, `done` and `err` are valid in the cycle after E8, i.e. latency is 8 clocks from the accept edge.
  - `done` is high for exactly one cycle, after E8 and up to E9.
  - `busy` falls at E8, together with `done` rising; `busy` and `done` are never high together.
- Back-to-back: with `enbl` held high, a new accept occurs at E9, giving one result per 9 cycles.
- `err` updates at the accept edge E0, not at `done`.
- With `enbl` low, `xout` and `err` hold indefinitely.

## Test plan
- `rst_n` low for 2 cycles, then `qin=32`, `yin=2`, `rin=0`, `enbl` pulsed 1 cycle -> after exactly 8 clocks `xout=64`, `done` pulses for one cycle, `err=0`, `busy` high for 8 cycles.
- Divider-bench vectors, one at a time:
  - (`qin`,`yin`,`rin`) = (2,2,1) -> `xout=5`.
  - (5,4,1) -> `xout=21`.
  - (27,3,0) -> `xout=81`.
  - (42,3,2) -> `xout=128`.
  - All with `err=0`.
- Extremes:
  - (255,255,254) -> `xout=65279`, `err=0`.
  - (0,7,3) -> `xout=3` after the full 8-cycle latency.
  - (9,0,0) -> `xout=0`, `err=1`.
  - (4,5,5) -> `xout=25`, `err=1`.
- `enbl` held high with operands changed during CALC -> change is ignored. The result matches the operands latched at accept, and the next accept occurs in the DONE cycle (9-cycle spacing).
- `rst_n` driven low at the 4th CALC cycle -> at the next edge `busy=0`, `xout=0`, `err=0`, and no `done` pulse. A fresh (10,10,9) afterwards gives `xout=109`.
